// File: rtl/issue_arbiter.sv
// Three-way issue arbiter (ALU/BRU/LSU): round-robin with anti-starvation promotion,
// with the multi-cycle LSU tracked as a busy resource until writeback or timeout.
module issue_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LSU_TIMEOUT  = 31,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic [2:0]       req_i,
    input  logic             lsu_done_i,
    output logic [2:0]       gnt_o,
    output logic             gnt_valid_o,
    output logic [1:0]       gnt_idx_o,
    output logic             lsu_busy_o,
    output logic             lsu_timeout_o,
    output logic [CNT_W-1:0] issue_cnt_o
);

    localparam int unsigned WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BUSY_W = (LSU_TIMEOUT < 1) ? 1 : $clog2(LSU_TIMEOUT + 1);

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

    lsu_state_e        lsu_state;
    logic [1:0]        rr_ptr;
    logic [WAIT_W-1:0] wait_cnt [3];
    logic [BUSY_W-1:0] busy_cnt;
    logic              lsu_timeout_q;

    logic              can_issue;
    logic [2:0]        eligible;
    logic [2:0]        starved;
    logic [2:0]        gnt;

    always_comb begin
        can_issue = rst_n & ~flush_i & ~hold_i;
        eligible  = req_i & {lsu_state != LSU_BUSY, 2'b11} & {3{can_issue}};
        for (int unsigned k = 0; k < 3; k++) begin
            starved[k] = eligible[k] & (wait_cnt[k] == WAIT_W'(STARVE_LIMIT));
        end

        gnt = '0;
        if (starved[0]) begin
            gnt = 3'b001;
        end else if (starved[1]) begin
            gnt = 3'b010;
        end else if (starved[2]) begin
            gnt = 3'b100;
        end else begin
            // Scan order starts at rr_ptr and wraps modulo 3.
            case (rr_ptr)
                2'd0: begin
                    if      (eligible[0]) gnt = 3'b001;
                    else if (eligible[1]) gnt = 3'b010;
                    else if (eligible[2]) gnt = 3'b100;
                end
                2'd1: begin
                    if      (eligible[1]) gnt = 3'b010;
                    else if (eligible[2]) gnt = 3'b100;
                    else if (eligible[0]) gnt = 3'b001;
                end
                default: begin
                    if      (eligible[2]) gnt = 3'b100;
                    else if (eligible[0]) gnt = 3'b001;
                    else if (eligible[1]) gnt = 3'b010;
                end
            endcase
        end
    end

    assign gnt_o         = gnt;
    assign gnt_valid_o   = |gnt;
    assign gnt_idx_o     = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
    assign lsu_busy_o    = (lsu_state == LSU_BUSY);
    assign lsu_timeout_o = lsu_timeout_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            lsu_state     <= LSU_IDLE;
            busy_cnt      <= '0;
            lsu_timeout_q <= 1'b0;
            for (int unsigned k = 0; k < 3; k++) begin
                wait_cnt[k] <= '0;
            end
        end else if (flush_i) begin
            rr_ptr        <= '0;
            lsu_state     <= LSU_IDLE;
            busy_cnt      <= '0;
            lsu_timeout_q <= 1'b0;
            for (int unsigned k = 0; k < 3; k++) begin
                wait_cnt[k] <= '0;
            end
        end else begin
            if (gnt[0]) begin
                rr_ptr <= 2'd1;
            end else if (gnt[1]) begin
                rr_ptr <= 2'd2;
            end else if (gnt[2]) begin
                rr_ptr <= 2'd0;
            end

            // Blocked or stalled requesters keep their count; only live contention ages them.
            for (int unsigned k = 0; k < 3; k++) begin
                if (gnt[k] || !req_i[k]) begin
                    wait_cnt[k] <= '0;
                end else if (!hold_i && eligible[k] &&
                             (wait_cnt[k] != WAIT_W'(STARVE_LIMIT))) begin
                    wait_cnt[k] <= wait_cnt[k] + WAIT_W'(1);
                end
            end

            lsu_timeout_q <= 1'b0;
            if (lsu_state == LSU_IDLE) begin
                if (gnt[2]) begin
                    lsu_state <= LSU_BUSY;
                    busy_cnt  <= '0;
                end
            end else begin
                busy_cnt <= busy_cnt + BUSY_W'(1);
                if (lsu_done_i) begin
                    lsu_state <= LSU_IDLE;
                end else if (busy_cnt == BUSY_W'(LSU_TIMEOUT - 1)) begin
                    lsu_state     <= LSU_IDLE;
                    lsu_timeout_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_o <= '0;
        end else if (|gnt) begin
            issue_cnt_o <= issue_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_arbiter.sv
// Bench for issue_arbiter: a default instance and a small-parameter instance share stimulus;
// a rule-level model checks both every cycle, directed literals pin key cases.
module tb_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, flush, hold, lsu_done;
    logic [2:0]  req;

    logic [2:0]  g0, g1;
    logic        gv0, gv1, b0, b1, t0, t1;
    logic [1:0]  gi0, gi1;
    logic [31:0] c0;
    logic [3:0]  c1;

    int n_tests = 0;
    int n_fail  = 0;

    issue_arbiter #(.STARVE_LIMIT(4), .LSU_TIMEOUT(31), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .hold_i(hold), .req_i(req),
        .lsu_done_i(lsu_done), .gnt_o(g0), .gnt_valid_o(gv0), .gnt_idx_o(gi0),
        .lsu_busy_o(b0), .lsu_timeout_o(t0), .issue_cnt_o(c0)
    );

    issue_arbiter #(.STARVE_LIMIT(1), .LSU_TIMEOUT(5), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .hold_i(hold), .req_i(req),
        .lsu_done_i(lsu_done), .gnt_o(g1), .gnt_valid_o(gv1), .gnt_idx_o(gi1),
        .lsu_busy_o(b1), .lsu_timeout_o(t1), .issue_cnt_o(c1)
    );

    always #5 clk = ~clk;

    // Model state per instance: index 0 = dut0, 1 = dut1
    int          m_rr    [2];
    int          m_w     [2][3];
    bit          m_busy  [2];
    int          m_bc    [2];
    bit          m_pulse [2];
    bit [31:0]   m_cnt   [2];
    int          lim     [2] = '{4, 1};
    int          tmo     [2] = '{31, 5};
    bit [31:0]   msk     [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
    bit          m_valid = 1'b0;

    function automatic int model_grant(int i);
        bit el [3];
        int k;
        if (!rst_n || flush || hold) return -1;
        for (int j = 0; j < 3; j++) el[j] = req[j] && !(j == 2 && m_busy[i]);
        for (int j = 0; j < 3; j++) if (el[j] && m_w[i][j] == lim[i]) return j;
        for (int j = 0; j < 3; j++) begin
            k = (m_rr[i] + j) % 3;
            if (el[k]) return k;
        end
        return -1;
    endfunction

    function automatic void model_adv(int i, int g);
        bit el [3];
        if (!rst_n || flush) begin
            m_rr[i] = 0; m_busy[i] = 0; m_bc[i] = 0; m_pulse[i] = 0;
            for (int j = 0; j < 3; j++) m_w[i][j] = 0;
            if (!rst_n) m_cnt[i] = 0;
            return;
        end
        for (int j = 0; j < 3; j++) el[j] = req[j] && !(j == 2 && m_busy[i]);
        if (g >= 0) begin
            m_cnt[i] = (m_cnt[i] + 1) & msk[i];
            m_rr[i]  = (g + 1) % 3;
        end
        for (int j = 0; j < 3; j++) begin
            if (g == j || !req[j]) m_w[i][j] = 0;
            else if (hold) m_w[i][j] = m_w[i][j];
            else if (el[j] && m_w[i][j] < lim[i]) m_w[i][j] = m_w[i][j] + 1;
        end
        m_pulse[i] = 0;
        if (m_busy[i]) begin
            if (lsu_done) m_busy[i] = 0;
            else begin
                m_bc[i] = m_bc[i] + 1;
                if (m_bc[i] == tmo[i]) begin
                    m_busy[i]  = 0;
                    m_pulse[i] = 1;
                end
            end
        end else if (g == 2) begin
            m_busy[i] = 1;
            m_bc[i]   = 0;
        end
    endfunction

    task automatic cmp(input int i, input int g, input logic [2:0] ag, input logic av,
                       input logic [1:0] ai, input logic ab, input logic at, input logic [31:0] ac);
        logic [2:0]  eg;
        logic        ev, et;
        logic [1:0]  ei;
        eg = (g < 0) ? 3'b000 : (3'b001 << g);
        ev = (g >= 0);
        ei = (g < 0) ? 2'd0 : 2'(g);
        et = rst_n && m_pulse[i];
        n_tests++;
        if ({ag, av, ai, ab, at, ac} !== {eg, ev, ei, m_busy[i], et, m_cnt[i]}) begin
            n_fail++;
            $display("FAIL model_dut%0d t=%0t: gnt=%b v=%b idx=%0d busy=%b to=%b cnt=%0d; expected gnt=%b v=%b idx=%0d busy=%b to=%b cnt=%0d",
                     i, $time, ag, av, ai, ab, at, ac, eg, ev, ei, m_busy[i], et, m_cnt[i]);
        end
    endtask

    always @(negedge clk) begin
        int ga, gb;
        ga = model_grant(0);
        gb = model_grant(1);
        if (m_valid) begin
            cmp(0, ga, g0, gv0, gi0, b0, t0, c0);
            cmp(1, gb, g1, gv1, gi1, b1, t1, {28'd0, c1});
        end
        model_adv(0, ga);
        model_adv(1, gb);
        if (!rst_n) m_valid = 1'b1;
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle, apply inputs just after the edge, settle before checks.
    task automatic cyc(input logic r, input logic [2:0] rq, input logic f, input logic h, input logic d);
        @(posedge clk);
        #1;
        rst_n = r; req = rq; flush = f; hold = h; lsu_done = d;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_a [6];
        int lsu_g, busy_n, hit;
        exp_a = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst_n = 1'b0; req = '0; flush = 1'b0; hold = 1'b0; lsu_done = 1'b0;

        repeat (3) cyc(0, 3'b000, 0, 0, 0);
        lit("reset_gnt", g0, 0);
        lit("reset_busy", b0, 0);
        lit("reset_cnt", c0, 0);

        // All three requesting, LSU writeback two cycles after each LSU grant
        lsu_g = -100;
        for (int n = 0; n < 14; n++) begin
            cyc(1, 3'b111, 0, 0, (n == lsu_g + 2));
            if (n < 6) lit($sformatf("rr_seq_%0d", n), g0, exp_a[n]);
            if (n == 1) lit("rr_idx_bru", gi0, 1);
            if (n == 2) lit("rr_idx_lsu", gi0, 2);
            if (n == 2) lit("promote_alu_limit1", g1, 3'b001);
            if (n == 3) lit("lsu_busy_after_grant", b0, 1);
            if (n == 5) lit("lsu_idle_after_done", b0, 0);
            if (g0[2]) lsu_g = n;
        end

        // LSU timeout with no writeback
        cyc(1, 3'b111, 1, 0, 0);
        lit("flush_no_grant", g0, 0);
        cyc(1, 3'b100, 0, 0, 0);
        lit("timeout_first_grant", g0, 3'b100);
        busy_n = 0;
        hit = -1;
        for (int n = 1; n <= 40 && hit < 0; n++) begin
            cyc(1, 3'b100, 0, 0, 0);
            if (t0) begin
                hit = n;
                lit("timeout_regrant", g0, 3'b100);
            end else if (b0) begin
                busy_n++;
            end
        end
        lit("timeout_busy_cycles", busy_n, 31);
        lit("timeout_offset", hit, 32);

        // Done and timeout coinciding on the small instance: release without pulse
        cyc(1, 3'b000, 1, 0, 0);
        cyc(1, 3'b100, 0, 0, 0);
        lit("coincide_grant", g1, 3'b100);
        repeat (4) cyc(1, 3'b000, 0, 0, 0);
        cyc(1, 3'b000, 0, 0, 1);
        cyc(1, 3'b000, 0, 0, 0);
        lit("coincide_no_pulse", t1, 0);
        lit("coincide_released", b1, 0);
        lit("done_release_dut0", b0, 0);

        // Writeback while idle is ignored; writeback while busy costs a bubble
        cyc(1, 3'b000, 0, 0, 1);
        cyc(1, 3'b100, 0, 0, 0);
        lit("idle_done_no_busy", b0, 0);
        lit("idle_done_grant", g0, 3'b100);
        cyc(1, 3'b100, 0, 0, 0);
        lit("busy_blocks_lsu", g0, 0);
        cyc(1, 3'b100, 0, 0, 1);
        lit("done_same_cycle_no_grant", g0, 0);
        cyc(1, 3'b100, 0, 0, 0);
        lit("done_next_cycle_grant", g0, 3'b100);

        // Flush while LSU busy and rr_ptr=2
        cyc(1, 3'b111, 1, 0, 0);
        cyc(1, 3'b100, 0, 0, 0);
        lit("pre_flush_lsu", g0, 3'b100);
        cyc(1, 3'b010, 0, 0, 0);
        lit("pre_flush_bru", g0, 3'b010);
        cyc(1, 3'b111, 1, 0, 0);
        lit("flush_gnt_zero", g0, 0);
        lit("flush_valid_zero", gv0, 0);
        cyc(1, 3'b111, 0, 0, 0);
        lit("post_flush_alu", g0, 3'b001);
        lit("post_flush_idle", b0, 0);

        // Global hold
        cyc(1, 3'b111, 1, 0, 0);
        cyc(1, 3'b111, 0, 0, 0);
        lit("pre_hold_alu", g0, 3'b001);
        for (int n = 0; n < 5; n++) begin
            cyc(1, 3'b111, 0, 1, 0);
            lit($sformatf("hold_no_grant_%0d", n), g0, 0);
        end
        cyc(1, 3'b111, 0, 0, 0);
        lit("post_hold_bru", g0, 3'b010);

        // Reset mid-operation with LSU busy and counters nonzero
        cyc(1, 3'b100, 0, 0, 0);
        lit("pre_reset_lsu", g0, 3'b100);
        cyc(0, 3'b111, 0, 0, 0);
        lit("reset_mid_gnt", g0, 0);
        lit("reset_mid_valid", gv0, 0);
        lit("reset_mid_timeout", t0, 0);
        cyc(0, 3'b111, 0, 0, 0);
        lit("reset_mid_busy", b0, 0);
        lit("reset_mid_cnt", c0, 0);
        lit("reset_mid_cnt_small", c1, 0);
        lit("reset_mid_idx", gi0, 0);
        cyc(1, 3'b111, 0, 0, 0);
        lit("post_reset_alu", g0, 3'b001);

        // Mixed traffic, checked by the model only
        for (int n = 0; n < 80; n++) begin
            cyc(1, 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        cyc(1, 3'b000, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
